// File: rtl/rr_burst_arbiter.sv
// Round-robin RX channel arbiter with urgent (almost-full) priority, burst hold
// of up to MAX_BURST accepted words, and optional urgent preemption.
module rr_burst_arbiter #(
   parameter  int NUM_CH    = 8,
   parameter  int MAX_BURST = 4,
   parameter  int PREEMPT   = 0,
   localparam int CH_W      = $clog2(NUM_CH),
   localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] rx_fifo_empty,
   input  logic [NUM_CH-1:0] rx_fifo_almost_full,
   input  logic              read_periph_data,
   input  logic              word_accepted,
   output logic [CH_W-1:0]   grant,
   output logic              grant_valid
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t            state;
   logic [CNT_W-1:0]  burst_cnt;
   logic [CH_W-1:0]   last_grant;

   logic [NUM_CH-1:0] req, urgent, pool, others_urgent;
   logic [CH_W-1:0]   sel, idx;
   logic              burst_done, release_now;

   assign req           = ~rx_fifo_empty;
   assign urgent        = req & rx_fifo_almost_full;
   assign pool          = (|urgent) ? urgent : req;
   assign others_urgent = urgent & ~(NUM_CH'(1) << grant);

   // Walk the ring from the farthest candidate back toward last_grant+1 so the
   // nearest set bit is the final assignment; last_grant itself ranks last.
   always_comb begin
      sel = last_grant;
      idx = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         idx = CH_W'((int'(last_grant) + k) % NUM_CH);
         if (pool[idx]) sel = idx;
      end
   end

   assign burst_done  = word_accepted && (burst_cnt == CNT_W'(MAX_BURST - 1));
   assign release_now = burst_done
                     || rx_fifo_empty[grant]
                     || !read_periph_data
                     || ((PREEMPT != 0) && !urgent[grant] && (|others_urgent));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= '0;
         grant_valid <= 1'b0;
         burst_cnt   <= '0;
         last_grant  <= CH_W'(NUM_CH - 1);
      end else begin
         case (state)
            IDLE: begin
               if (read_periph_data && (|req)) begin
                  grant       <= sel;
                  grant_valid <= 1'b1;
                  burst_cnt   <= '0;
                  state       <= HOLD;
               end else begin
                  grant_valid <= 1'b0;
               end
            end
            HOLD: begin
               // A word accepted on the release cycle is consumed by the reset
               // of the counter; only one release happens however many causes.
               if (release_now) begin
                  grant_valid <= 1'b0;
                  last_grant  <= grant;
                  burst_cnt   <= '0;
                  state       <= IDLE;
               end else if (word_accepted) begin
                  burst_cnt   <= burst_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
